// File: rtl/capture_ctrl_if.sv
// Capture controller bus: the command/config inputs and channel trigger flags
// going in, the arming, status and sample-RAM write signals coming back out.
interface capture_ctrl_if #(
    parameter int NUM_CH = 5,
    parameter int AW     = 9
);
    logic [NUM_CH-1:0] CH_Trig;
    logic              capture_en;
    logic              clr_done;
    logic              smpl_en;
    logic [AW-1:0]     trig_pos;
    logic              armed;
    logic              triggered;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     trig_addr;
    logic              capture_done;

    // Command/config side and channel trigger blocks.
    modport master (
        output CH_Trig, capture_en, clr_done, smpl_en, trig_pos,
        input  armed, triggered, we, waddr, trig_addr, capture_done
    );

    // The capture controller itself.
    modport slave (
        input  CH_Trig, capture_en, clr_done, smpl_en, trig_pos,
        output armed, triggered, we, waddr, trig_addr, capture_done
    );
endinterface

// File: rtl/capture_ctrl.sv
// Capture/trigger controller: pre-trigger fill, armed wait, post-trigger count,
// done. Writes samples circularly into a DEPTH-entry RAM and records where the
// trigger landed so the readout can unroll the buffer.
module capture_ctrl #(
    parameter int NUM_CH = 5,
    parameter int DEPTH  = 384,
    parameter int AW     = 9
) (
    input  logic         clk,
    input  logic         rst,
    capture_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_nx;
    logic          armed_q, armed_nx;
    logic          trig_q, trig_nx;
    logic          done_q, done_nx;
    logic [AW-1:0] waddr_q, waddr_nx;
    logic [AW-1:0] taddr_q, taddr_nx;
    logic [AW-1:0] pre_cnt, pre_nx;
    logic [AW-1:0] post_cnt, post_nx;

    logic [AW-1:0] tp;
    logic [AW-1:0] waddr_inc;
    logic [AW:0]   pre_inc, post_inc, pre_target;
    logic          trig;

    // Out-of-range trigger positions collapse to the largest legal one.
    assign tp         = (bus.trig_pos >= LAST) ? LAST : bus.trig_pos;
    assign pre_target = DEPTH_W - {1'b0, tp};
    assign pre_inc    = {1'b0, pre_cnt} + (AW+1)'(1);
    assign post_inc   = {1'b0, post_cnt} + (AW+1)'(1);
    assign waddr_inc  = (waddr_q == LAST) ? '0 : waddr_q + 1'b1;

    // Registered armed gates the trigger, so channel flags left over from
    // before arming cannot fire it.
    assign trig = armed_q & (&bus.CH_Trig);

    // Next-state and datapath updates; everything holds unless a branch says otherwise.
    always_comb begin
        state_nx = state;
        armed_nx = armed_q;
        trig_nx  = trig_q;
        done_nx  = done_q;
        waddr_nx = waddr_q;
        taddr_nx = taddr_q;
        pre_nx   = pre_cnt;
        post_nx  = post_cnt;
        case (state)
            IDLE, DONE: begin
                // A start beats a simultaneous clear; both leave done low.
                if (bus.capture_en) begin
                    state_nx = FILL;
                    waddr_nx = '0;
                    pre_nx   = '0;
                    trig_nx  = 1'b0;
                    done_nx  = 1'b0;
                end else if (bus.clr_done) begin
                    done_nx = 1'b0;
                end
            end
            FILL: begin
                if (bus.smpl_en) begin
                    waddr_nx = waddr_inc;
                    pre_nx   = pre_inc[AW-1:0];
                    // >= rather than == so a shrinking trig_pos cannot strand us in FILL.
                    if (pre_inc >= pre_target) begin
                        state_nx = ARMED;
                        armed_nx = 1'b1;
                    end
                end
            end
            ARMED: begin
                // A sample coinciding with the trigger is still pre-trigger history.
                if (bus.smpl_en) waddr_nx = waddr_inc;
                if (trig) begin
                    trig_nx  = 1'b1;
                    taddr_nx = waddr_q;
                    post_nx  = '0;
                    armed_nx = 1'b0;
                    if (tp == '0) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = POST;
                    end
                end
            end
            POST: begin
                if (bus.smpl_en) begin
                    waddr_nx = waddr_inc;
                    post_nx  = post_inc[AW-1:0];
                    if (post_inc >= {1'b0, tp}) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any capture in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            armed_q  <= 1'b0;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
            waddr_q  <= '0;
            taddr_q  <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
        end else begin
            state    <= state_nx;
            armed_q  <= armed_nx;
            trig_q   <= trig_nx;
            done_q   <= done_nx;
            waddr_q  <= waddr_nx;
            taddr_q  <= taddr_nx;
            pre_cnt  <= pre_nx;
            post_cnt <= post_nx;
        end
    end

    assign bus.we           = bus.smpl_en & ((state == FILL) | (state == ARMED) | (state == POST));
    assign bus.armed        = armed_q;
    assign bus.triggered    = trig_q;
    assign bus.capture_done = done_q;
    assign bus.waddr        = waddr_q;
    assign bus.trig_addr    = taddr_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a write-count model of the capture.
module tb_capture_ctrl;
    localparam int NUM_CH = 5;
    localparam int DEPTH  = 384;
    localparam int AW     = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    capture_ctrl_if #(.NUM_CH(NUM_CH), .AW(AW)) bus();
    capture_ctrl #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: a capture is described by how many samples were written since
    // it started, whether the trigger has been seen, and how many came after.
    bit m_started, m_fin, m_trig_seen, m_done;
    int m_writes, m_post, m_tp, m_taddr;

    function automatic bit m_capturing();
        return m_started && !m_fin;
    endfunction

    function automatic bit m_armed();
        return m_capturing() && !m_trig_seen && (m_writes >= DEPTH - m_tp);
    endfunction

    function automatic logic [NUM_CH-1:0] one_zero();
        logic [NUM_CH-1:0] c;
        c = '1;
        c[$urandom_range(0, NUM_CH-1)] = 1'b0;
        return c;
    endfunction

    task automatic model_step(input bit r, en, clr, smp, input logic [NUM_CH-1:0] ch, input int tpin);
        bit trig;
        if (r) begin
            m_started = 0; m_fin = 0; m_trig_seen = 0; m_done = 0;
            m_writes = 0; m_post = 0; m_taddr = 0;
            return;
        end
        trig = m_armed() && (&ch);
        if (!m_capturing()) begin
            if (en) begin
                m_started = 1; m_fin = 0; m_trig_seen = 0; m_done = 0;
                m_writes = 0; m_post = 0;
                m_tp = (tpin >= DEPTH) ? DEPTH - 1 : tpin;
            end else if (clr) begin
                m_done = 0;
            end
        end else if (trig) begin
            m_taddr = m_writes % DEPTH;
            m_trig_seen = 1;
            if (smp) m_writes++;
            if (m_tp == 0) begin m_fin = 1; m_done = 1; end
        end else if (smp) begin
            m_writes++;
            if (m_trig_seen) begin
                m_post++;
                if (m_post == m_tp) begin m_fin = 1; m_done = 1; end
            end
        end
    endtask

    // One clock: drive at negedge, check outputs, update the model at posedge.
    task automatic cyc(input bit r, en, clr, smp, input logic [NUM_CH-1:0] ch, input int tpin);
        @(negedge clk);
        rst            = r;
        bus.capture_en = en;
        bus.clr_done   = clr;
        bus.smpl_en    = smp;
        bus.CH_Trig    = ch;
        bus.trig_pos   = AW'(tpin);
        #1;
        chk("armed",        int'(bus.armed),        int'(m_armed()));
        chk("triggered",    int'(bus.triggered),    int'(m_trig_seen));
        chk("capture_done", int'(bus.capture_done), int'(m_done));
        chk("waddr",        int'(bus.waddr),        m_writes % DEPTH);
        chk("trig_addr",    int'(bus.trig_addr),    m_taddr);
        chk("we",           int'(bus.we),           int'(smp && m_capturing()));
        @(posedge clk);
        model_step(r, en, clr, smp, ch, tpin);
    endtask

    logic [NUM_CH-1:0] all1;
    int cur_tp;

    initial begin
        all1 = '1;
        rst = 1'b1;
        bus.capture_en = 1'b1; bus.clr_done = 1'b0; bus.smpl_en = 1'b0;
        bus.CH_Trig = '0; bus.trig_pos = '0;

        // Reset beats capture_en.
        cyc(1, 1, 0, 0, all1, 100);
        cyc(1, 1, 0, 0, all1, 100);
        #2;
        chk("t1_armed", int'(bus.armed), 0);
        chk("t1_done",  int'(bus.capture_done), 0);
        chk("t1_waddr", int'(bus.waddr), 0);
        chk("t1_we",    int'(bus.we), 0);

        // trig_pos=100: armed after 284 writes, trigger after 400 writes.
        cyc(0, 1, 0, 0, all1, 100);
        for (int i = 0; i < 283; i++) cyc(0, 0, 0, 1, all1, 100);
        #2; chk("t2_not_armed", int'(bus.armed), 0);
        cyc(0, 0, 0, 1, all1, 100);
        #2; chk("t2_armed", int'(bus.armed), 1);
        for (int i = 284; i < 400; i++) cyc(0, 0, 0, 1, one_zero(), 100);
        #2; chk("t2_hold_armed", int'(bus.armed), 1);
        cyc(0, 0, 0, 0, all1, 100);
        #2;
        chk("t2_armed_low", int'(bus.armed), 0);
        chk("t2_trig_addr", int'(bus.trig_addr), 16);
        for (int i = 0; i < 99; i++) cyc(0, 0, 0, 1, NUM_CH'($urandom), 100);
        #2; chk("t2_not_done", int'(bus.capture_done), 0);
        cyc(0, 0, 0, 1, all1, 100);
        #2;
        chk("t2_done",  int'(bus.capture_done), 1);
        chk("t2_waddr", int'(bus.waddr), 116);

        // trig_pos=0: trigger with a sample goes straight to DONE.
        cyc(0, 1, 0, 0, all1, 0);
        for (int i = 0; i < 384; i++) cyc(0, 0, 0, 1, all1, 0);
        cyc(0, 0, 0, 1, all1, 0);
        #2;
        chk("t3_done",      int'(bus.capture_done), 1);
        chk("t3_trig_addr", int'(bus.trig_addr), 0);
        chk("t3_waddr",     int'(bus.waddr), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, all1, 0);
        #2; chk("t3_frozen", int'(bus.waddr), 1);

        // One channel low keeps the controller armed.
        cyc(0, 1, 0, 0, all1, 300);
        for (int i = 0; i < 84; i++) cyc(0, 0, 0, 1, all1, 300);
        for (int i = 0; i < 200; i++) cyc(0, 0, 0, 1, one_zero(), 300);
        #2;
        chk("t4_armed",   int'(bus.armed), 1);
        chk("t4_no_trig", int'(bus.triggered), 0);

        // capture_en in POST is ignored; en+clr in DONE restarts with done low.
        cyc(0, 0, 0, 1, all1, 300);
        cyc(0, 1, 0, 1, NUM_CH'($urandom), 300);
        #2; chk("t5_en_ignored", int'(bus.triggered), 1);
        for (int i = 0; i < 299; i++) cyc(0, 0, 0, 1, NUM_CH'($urandom), 300);
        #2; chk("t5_done", int'(bus.capture_done), 1);
        cyc(0, 1, 1, 0, all1, 20);
        #2;
        chk("t5_restart_done", int'(bus.capture_done), 0);
        chk("t5_restart_trig", int'(bus.triggered), 0);
        chk("t5_restart_addr", int'(bus.waddr), 0);

        // Reset mid-POST, then a clean restart.
        for (int i = 0; i < 364; i++) cyc(0, 0, 0, 1, all1, 20);
        cyc(0, 0, 0, 0, all1, 20);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, all1, 20);
        cyc(1, 0, 0, 1, all1, 20);
        #2;
        chk("t6_armed", int'(bus.armed), 0);
        chk("t6_trig",  int'(bus.triggered), 0);
        chk("t6_waddr", int'(bus.waddr), 0);
        chk("t6_taddr", int'(bus.trig_addr), 0);
        cyc(0, 1, 0, 0, all1, 383);
        #2; chk("t6_armed_low", int'(bus.armed), 0);
        cyc(0, 0, 0, 1, all1, 383);
        #2; chk("t6_rearmed", int'(bus.armed), 1);

        // Random traffic.
        cur_tp = 383;
        for (int n = 0; n < 14000; n++) begin
            bit r, en, clr, smp;
            logic [NUM_CH-1:0] ch;
            r   = ($urandom_range(0, 3999) == 0);
            en  = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 39) == 0);
            smp = ($urandom_range(0, 9) < 7);
            if (m_armed())
                ch = ($urandom_range(0, 19) == 0) ? all1 : one_zero();
            else
                ch = $urandom_range(0, 1) ? all1 : NUM_CH'($urandom);
            if (!m_capturing()) begin
                case ($urandom_range(0, 5))
                    0:       cur_tp = 0;
                    1:       cur_tp = 1;
                    2:       cur_tp = 383;
                    3:       cur_tp = $urandom_range(384, 511);
                    default: cur_tp = $urandom_range(0, 383);
                endcase
            end
            cyc(r, en, clr, smp, ch, cur_tp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
